interval_timer_ctrl: RTL and testbench
======================================

Name: interval_timer_ctrl

Overview:
- Workout sequencer for the fitness timer: runs PREP -> WORK -> REST rounds from the 1 Hz tick strobe, which is derived from clock_divider's clk_1Hz.
- Drives remaining-seconds and round counters for the display path.
- Drives a buzzer tone select that muxes the divider's 500 Hz / 1 kHz / 2 kHz outputs downstream.
- Sits between the debounced buttons/config switches and the display/buzzer logic.

Parameters:
PREP_SEC, 3, length of the PREP countdown in seconds (>=1)
SEC_W, 8, width of second counters and work/rest config
ROUND_W, 6, width of round counters and rounds config
DONE_BEEP, 3, ticks of buzzer at workout completion (>=1)

Ports:
clk_in  input  1  system clock (40 MHz)
reset  input  1  asynchronous, active-low reset (0 = reset)
tick_1hz  input  1  one-cycle strobe per second, synchronous to clk_in
start  input  1  one-cycle pulse, debounced
pause  input  1  one-cycle pulse, toggles pause
stop  input  1  one-cycle pulse, abort to IDLE
cfg_work  input  SEC_W  work seconds, latched on accepted start
cfg_rest  input  SEC_W  rest seconds, latched on accepted start
cfg_rounds  input  ROUND_W  round count, latched on accepted start
phase  output  3  0 IDLE, 1 PREP, 2 WORK, 3 REST, 4 DONE
sec_left  output  SEC_W  seconds remaining in current phase
round_num  output  ROUND_W  current round, 1-based; 0 in IDLE
paused  output  1  pause flag
done  output  1  high while in DONE
tone_sel  output  2  0 off, 1 500 Hz, 2 1 kHz, 3 2 kHz

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: phase=IDLE, sec_left=0, round_num=0, paused=0, done=0, tone_sel=0.
  - Internal: latched config=0, beep_left=0.
- All outputs are registered. Every response appears the clk_in edge after the causing input is sampled (1-cycle latency).
- Input priority in a cycle: stop > start > pause > tick_1hz.
- stop: from any state -> IDLE with reset values (latched config is kept). stop in IDLE is a no-op.
- IDLE:
  - start with cfg_work!=0 and cfg_rounds!=0 -> latch config; enter PREP with sec_left=PREP_SEC, round_num=1.
  - start with cfg_work=0 or cfg_rounds=0 is ignored.
- Countdown rule, in PREP/WORK/REST while paused=0:
  - Each tick with sec_left>1 decrements sec_left.
  - A tick with sec_left==1 causes the phase exit. An N-second phase therefore spans exactly N ticks.
- Phase exits:
  - PREP -> WORK, sec_left=work.
  - WORK, round_num<rounds, rest!=0 -> REST, sec_left=rest.
  - WORK, round_num<rounds, rest==0 -> WORK, round_num+1, sec_left=work.
  - WORK, round_num==rounds -> DONE, sec_left=0, done=1.
  - REST -> WORK, round_num+1, sec_left=work.
- pause:
  - Toggles paused only in PREP/WORK/REST; ignored in IDLE/DONE.
  - A tick in the same cycle as a pause pulse is evaluated against the pre-toggle paused value.
  - While paused: ticks ignored, tone_sel forced to 0, beep_left frozen.
- DONE: holds until start (acts like start from IDLE, re-latching config) or stop (-> IDLE). paused=0 in DONE.
- Buzzer (beep_left counts ticks, tone register holds the tone):
  - PREP entry and each PREP decrement: tone 1, beep_left=1.
  - WORK entry: tone 3, beep_left=1.
  - REST entry: tone 2, beep_left=1.
  - DONE entry: tone 3, beep_left=DONE_BEEP.
  - Each unpaused tick that does not load a new beep decrements beep_left.
  - tone_sel = tone when beep_left!=0 and paused=0, else 0.
  - A new beep overrides a running one.
- Reset mid-operation: immediate return to reset values; no beep.
- Counters never wrap. sec_left never underflows below 0; round_num never exceeds rounds.

Test Plan:
- Reset=0 mid-WORK (sec_left=5) -> all outputs 0 asynchronously, before the next clk_in edge; after release, start needed to run again.
- cfg_work=4, cfg_rest=2, cfg_rounds=2, start, then 3+4+2+4 ticks:
  - phases: PREP(3,2,1) -> WORK r1(4..1) -> REST(2,1) -> WORK r2(4..1) -> DONE, done=1.
  - tone_sel 3 for DONE_BEEP=3 ticks, then 0.
- cfg_rest=0, cfg_rounds=3, cfg_work=2 -> WORK->WORK back-to-back, round_num 1,2,3, no REST phase, tone 3 at each WORK entry.
- In WORK with sec_left=3: pause, then 5 ticks -> sec_left stays 3, tone_sel=0. Pause again, then 1 tick -> sec_left=2.
- Tick and stop in the same cycle in REST -> phase=IDLE, sec_left=0, round_num=0 next cycle. Tick and pause in the same cycle (unpaused) -> sec_left decrements and paused=1.
- start with cfg_rounds=0 -> stays IDLE. start in DONE with new cfg_work=1 -> PREP with sec_left=3 and the new config latched.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// -----------------------------------------------------------------------------
// interval_timer_ctrl
//   Workout sequencer for the fitness timer. It runs PREP -> WORK -> REST rounds
//   off the 1 Hz tick strobe. It drives the remaining-seconds and round counters
//   for the display, and a buzzer tone select for the divider mux downstream.
//
// Ports
//   clk_in      system clock
//   reset       asynchronous, active-low reset
//   tick_1hz    one-cycle strobe per second
//   start       one-cycle pulse; latches cfg_* and starts a workout
//   pause       one-cycle pulse; toggles pause while a workout runs
//   stop        one-cycle pulse; abort to IDLE
//   cfg_work    work seconds
//   cfg_rest    rest seconds (0 = no rest phase)
//   cfg_rounds  number of rounds
//   phase       0 IDLE, 1 PREP, 2 WORK, 3 REST, 4 DONE
//   sec_left    seconds remaining in the current phase
//   round_num   current round, 1-based; 0 in IDLE
//   paused      pause flag
//   done        high while in DONE
//   tone_sel    0 off, 1 500 Hz, 2 1 kHz, 3 2 kHz
// -----------------------------------------------------------------------------
module interval_timer_ctrl #(
  parameter int PREP_SEC  = 3,
  parameter int SEC_W     = 8,
  parameter int ROUND_W   = 6,
  parameter int DONE_BEEP = 3
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [SEC_W-1:0]   cfg_work,
  input  logic [SEC_W-1:0]   cfg_rest,
  input  logic [ROUND_W-1:0] cfg_rounds,
  output logic [2:0]         phase,
  output logic [SEC_W-1:0]   sec_left,
  output logic [ROUND_W-1:0] round_num,
  output logic               paused,
  output logic               done,
  output logic [1:0]         tone_sel
);

  localparam int BEEP_W = $clog2(DONE_BEEP + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_WORK = 3'd2,
    S_REST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state,     w_state;
  logic [SEC_W-1:0]   r_sec,       w_sec;
  logic [ROUND_W-1:0] r_round,     w_round;
  logic               r_paused,    w_paused;
  logic [SEC_W-1:0]   r_cfg_work,  w_cfg_work;
  logic [SEC_W-1:0]   r_cfg_rest,  w_cfg_rest;
  logic [ROUND_W-1:0] r_cfg_rnds,  w_cfg_rnds;
  logic [1:0]         r_tone,      w_tone;
  logic [BEEP_W-1:0]  r_beep,      w_beep;
  logic [1:0]         r_tone_sel,  w_tone_sel;
  logic               r_done,      w_done;

  logic               w_clear;      // stop from a non-IDLE state
  logic               w_load;       // a phase event loads a new beep
  logic [1:0]         w_load_tone;
  logic [BEEP_W-1:0]  w_load_beep;
  logic               w_tick;       // tick that is not masked by pause
  logic               w_start_ok;
  logic               w_running;

  assign w_tick     = tick_1hz && !r_paused;
  assign w_start_ok = start && (cfg_work != '0) && (cfg_rounds != '0);
  assign w_running  = (r_state == S_PREP) || (r_state == S_WORK) ||
                      (r_state == S_REST);

  // State and datapath registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sec      <= '0;
      r_round    <= '0;
      r_paused   <= 1'b0;
      r_cfg_work <= '0;
      r_cfg_rest <= '0;
      r_cfg_rnds <= '0;
      r_tone     <= 2'd0;
      r_beep     <= '0;
      r_tone_sel <= 2'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sec      <= w_sec;
      r_round    <= w_round;
      r_paused   <= w_paused;
      r_cfg_work <= w_cfg_work;
      r_cfg_rest <= w_cfg_rest;
      r_cfg_rnds <= w_cfg_rnds;
      r_tone     <= w_tone;
      r_beep     <= w_beep;
      r_tone_sel <= w_tone_sel;
      r_done     <= w_done;
    end
  end

  // Next state: stop > start > pause > tick
  always_comb begin
    w_state     = r_state;
    w_sec       = r_sec;
    w_round     = r_round;
    w_paused    = r_paused;
    w_cfg_work  = r_cfg_work;
    w_cfg_rest  = r_cfg_rest;
    w_cfg_rnds  = r_cfg_rnds;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_load_tone = 2'd0;
    w_load_beep = '0;
    if (stop) begin
      if (r_state != S_IDLE) begin
        w_clear  = 1'b1;
        w_state  = S_IDLE;
        w_sec    = '0;
        w_round  = '0;
        w_paused = 1'b0;
      end
    end else if (w_start_ok && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
      w_cfg_work  = cfg_work;
      w_cfg_rest  = cfg_rest;
      w_cfg_rnds  = cfg_rounds;
      w_state     = S_PREP;
      w_sec       = SEC_W'(PREP_SEC);
      w_round     = ROUND_W'(1);
      w_paused    = 1'b0;
      w_load      = 1'b1;
      w_load_tone = 2'd1;
      w_load_beep = BEEP_W'(1);
    end else if (w_running) begin
      if (pause) w_paused = !r_paused;
      // Tick is judged against the pre-toggle pause flag
      if (w_tick) begin
        if (r_sec > SEC_W'(1)) begin
          w_sec = r_sec - SEC_W'(1);
          if (r_state == S_PREP) begin
            w_load      = 1'b1;
            w_load_tone = 2'd1;
            w_load_beep = BEEP_W'(1);
          end
        end else if (r_sec == SEC_W'(1)) begin
          w_load      = 1'b1;
          w_load_beep = BEEP_W'(1);
          case (r_state)
            S_PREP: begin
              w_state     = S_WORK;
              w_sec       = r_cfg_work;
              w_load_tone = 2'd3;
            end
            S_WORK: begin
              if (r_round >= r_cfg_rnds) begin
                w_state     = S_DONE;
                w_sec       = '0;
                w_paused    = 1'b0;
                w_load_tone = 2'd3;
                w_load_beep = BEEP_W'(DONE_BEEP);
              end else if (r_cfg_rest != '0) begin
                w_state     = S_REST;
                w_sec       = r_cfg_rest;
                w_load_tone = 2'd2;
              end else begin
                w_round     = r_round + ROUND_W'(1);
                w_sec       = r_cfg_work;
                w_load_tone = 2'd3;
              end
            end
            default: begin  // S_REST
              w_state     = S_WORK;
              w_round     = r_round + ROUND_W'(1);
              w_sec       = r_cfg_work;
              w_load_tone = 2'd3;
            end
          endcase
        end
      end
    end
  end

  // Buzzer and registered output values
  always_comb begin
    w_tone = r_tone;
    w_beep = r_beep;
    if (w_clear) begin
      w_tone = 2'd0;
      w_beep = '0;
    end else if (w_load) begin
      w_tone = w_load_tone;
      w_beep = w_load_beep;
    end else if (w_tick && (r_beep != '0)) begin
      w_beep = r_beep - BEEP_W'(1);
    end
    w_done     = (w_state == S_DONE);
    w_tone_sel = ((w_beep != '0) && !w_paused) ? w_tone : 2'd0;
  end

  assign phase     = r_state;
  assign sec_left  = r_sec;
  assign round_num = r_round;
  assign paused    = r_paused;
  assign done      = r_done;
  assign tone_sel  = r_tone_sel;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
module tb_interval_timer_ctrl;

  localparam int PREP_SEC  = 3;
  localparam int SEC_W     = 8;
  localparam int ROUND_W   = 6;
  localparam int DONE_BEEP = 3;

  localparam int P_IDLE = 0, P_PREP = 1, P_WORK = 2, P_REST = 3, P_DONE = 4;

  logic               clk_in = 1'b0;
  logic               reset  = 1'b1;
  logic               tick_1hz = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [SEC_W-1:0]   cfg_work = '0, cfg_rest = '0;
  logic [ROUND_W-1:0] cfg_rounds = '0;
  logic [2:0]         phase;
  logic [SEC_W-1:0]   sec_left;
  logic [ROUND_W-1:0] round_num;
  logic               paused, done;
  logic [1:0]         tone_sel;

  interval_timer_ctrl #(
    .PREP_SEC(PREP_SEC), .SEC_W(SEC_W), .ROUND_W(ROUND_W), .DONE_BEEP(DONE_BEEP)
  ) dut (
    .clk_in(clk_in), .reset(reset), .tick_1hz(tick_1hz), .start(start),
    .pause(pause), .stop(stop), .cfg_work(cfg_work), .cfg_rest(cfg_rest),
    .cfg_rounds(cfg_rounds), .phase(phase), .sec_left(sec_left),
    .round_num(round_num), .paused(paused), .done(done), .tone_sel(tone_sel)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: workout state kept as plain integers
  int m_phase, m_sec, m_round, m_paused, m_tone, m_beep;
  int m_work, m_rest, m_rounds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_sec = 0; m_round = 0; m_paused = 0; m_tone = 0; m_beep = 0;
    m_work = 0; m_rest = 0; m_rounds = 0;
  endtask

  function automatic void beep(input int tone, input int len);
    m_tone = tone;
    m_beep = len;
  endfunction

  task automatic model_step(input bit t, input bit st, input bit pa, input bit sp);
    bit running, was_paused, new_beep;
    running    = (m_phase == P_PREP) || (m_phase == P_WORK) || (m_phase == P_REST);
    was_paused = (m_paused != 0);
    new_beep   = 0;
    if (sp) begin
      if (m_phase != P_IDLE) begin
        m_phase = P_IDLE; m_sec = 0; m_round = 0; m_paused = 0; m_tone = 0; m_beep = 0;
      end
    end else if (st && (m_phase == P_IDLE || m_phase == P_DONE) &&
                 cfg_work != 0 && cfg_rounds != 0) begin
      m_work = int'(cfg_work); m_rest = int'(cfg_rest); m_rounds = int'(cfg_rounds);
      m_phase = P_PREP; m_sec = PREP_SEC; m_round = 1; m_paused = 0;
      beep(1, 1);
    end else begin
      if (pa && running) m_paused = was_paused ? 0 : 1;
      if (t && !was_paused) begin
        if (running) begin
          new_beep = 1;
          if (m_sec > 1) begin
            m_sec = m_sec - 1;
            if (m_phase == P_PREP) beep(1, 1);
            else new_beep = 0;
          end else if (m_phase == P_PREP) begin
            m_phase = P_WORK; m_sec = m_work; beep(3, 1);
          end else if (m_phase == P_REST) begin
            m_phase = P_WORK; m_round++; m_sec = m_work; beep(3, 1);
          end else if (m_round == m_rounds) begin
            m_phase = P_DONE; m_sec = 0; m_paused = 0; beep(3, DONE_BEEP);
          end else if (m_rest != 0) begin
            m_phase = P_REST; m_sec = m_rest; beep(2, 1);
          end else begin
            m_round++; m_sec = m_work; beep(3, 1);
          end
        end
        if (!new_beep && m_beep > 0) m_beep--;
      end
    end
  endtask

  task automatic check_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("sec_left", 32'(sec_left), 32'(m_sec));
    chk("round_num", 32'(round_num), 32'(m_round));
    chk("paused", 32'(paused), 32'(m_paused));
    chk("done", 32'(done), 32'(m_phase == P_DONE));
    chk("tone_sel", 32'(tone_sel), 32'((m_beep != 0 && m_paused == 0) ? m_tone : 0));
  endtask

  // Called 1 time unit after a rising edge; returns at the same offset.
  task automatic cyc(input bit t, input bit st, input bit pa, input bit sp);
    tick_1hz = t; start = st; pause = pa; stop = sp;
    @(posedge clk_in);
    model_step(t, st, pa, sp);
    #1;
    tick_1hz = 0; start = 0; pause = 0; stop = 0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic set_cfg(input int w, input int r, input int n);
    cfg_work = SEC_W'(w); cfg_rest = SEC_W'(r); cfg_rounds = ROUND_W'(n);
  endtask

  int saw_rest;

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1 check_all();
    @(posedge clk_in); #1;
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Full workout 4/2/2
    set_cfg(4, 2, 2);
    cyc(0, 1, 0, 0);
    chk("prep_entry_sec", 32'(sec_left), 32'd3);
    chk("prep_entry_tone", 32'(tone_sel), 32'd1);
    ticks(3);
    chk("work1_sec", 32'(sec_left), 32'd4);
    chk("work1_tone", 32'(tone_sel), 32'd3);
    ticks(4);
    chk("rest_phase", 32'(phase), 32'd3);
    ticks(2);
    chk("work2_round", 32'(round_num), 32'd2);
    ticks(4);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_tone", 32'(tone_sel), 32'd3);
    ticks(2);
    chk("done_tone_last", 32'(tone_sel), 32'd3);
    ticks(1);
    chk("done_tone_off", 32'(tone_sel), 32'd0);

    // Back-to-back WORK, no REST
    cyc(0, 0, 0, 1);
    set_cfg(2, 0, 3);
    cyc(0, 1, 0, 0);
    saw_rest = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 0, 0);
      if (phase == 3'd3) saw_rest++;
    end
    chk("no_rest_phase", 32'(saw_rest), 32'd0);
    chk("b2b_done_round", 32'(round_num), 32'd3);

    // Pause in WORK at sec_left=3
    cyc(0, 0, 0, 1);
    set_cfg(6, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(6);
    chk("pre_pause_sec", 32'(sec_left), 32'd3);
    cyc(0, 0, 1, 0);
    ticks(5);
    chk("paused_sec", 32'(sec_left), 32'd3);
    chk("paused_tone", 32'(tone_sel), 32'd0);
    cyc(0, 0, 1, 0);
    ticks(1);
    chk("resumed_sec", 32'(sec_left), 32'd2);

    // Tick+stop in REST; tick+pause in WORK
    cyc(0, 0, 0, 1);
    set_cfg(2, 2, 2);
    cyc(0, 1, 0, 0);
    ticks(5);
    chk("in_rest", 32'(phase), 32'd3);
    cyc(1, 0, 0, 1);
    chk("stop_phase", 32'(phase), 32'd0);
    cyc(0, 1, 0, 0);
    ticks(3);
    cyc(1, 0, 1, 0);
    chk("tp_sec", 32'(sec_left), 32'd1);
    chk("tp_paused", 32'(paused), 32'd1);

    // Invalid start, then restart from DONE with new config
    cyc(0, 0, 0, 1);
    set_cfg(3, 0, 0);
    cyc(0, 1, 0, 0);
    chk("bad_start_idle", 32'(phase), 32'd0);
    set_cfg(2, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(5);
    set_cfg(1, 1, 2);
    cyc(0, 1, 0, 0);
    chk("redo_prep_sec", 32'(sec_left), 32'd3);
    ticks(3);
    chk("redo_work_sec", 32'(sec_left), 32'd1);

    // Async reset mid-WORK at sec_left=5
    cyc(0, 0, 0, 1);
    set_cfg(6, 0, 1);
    cyc(0, 1, 0, 0);
    ticks(4);
    chk("pre_reset_sec", 32'(sec_left), 32'd5);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk_in); #1;
    reset = 1'b1;
    cyc(1, 0, 0, 0);
    chk("post_reset_idle", 32'(phase), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit t, st, pa, sp;
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      t  = ($urandom_range(0, 99) < 40);
      pa = ($urandom_range(0, 99) < 5);
      sp = ($urandom_range(0, 199) < 3);
      st = (m_phase == P_IDLE || m_phase == P_DONE) && ($urandom_range(0, 99) < 20);
      cyc(t, st, pa, sp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
